// File: rtl/pkt_bus_pkg.sv
// pkt_bus_pkg: shared FSM states, byte width and last_bytes width helper for the packet bus transmitter
package pkt_bus_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_GAP} state_e;
  localparam int BYTE_WIDTH = 8;
  function automatic int lb_width(input int bus_bytes);
    return $clog2(bus_bytes + 1);
  endfunction
endpackage

// File: rtl/pkt_bus_out_reg.sv
// pkt_bus_out_reg: valid/ready output word register with sop/eop/last_bytes sideband
// Ports: clk, reset (sync, active-low); load_i/data_i/sop_i/eop_i/last_bytes_i capture a word;
// can_load_o says the register is empty or draining this cycle; bus_o/valid_o/start_of_packet_o/
// end_of_packet_o/last_bytes_o hold the presented word, ready_i drains it.
module pkt_bus_out_reg
  import pkt_bus_pkg::*;
#(
  parameter int BUS_BYTES = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load_i,
  input  logic [BUS_BYTES*BYTE_WIDTH-1:0]   data_i,
  input  logic                              sop_i,
  input  logic                              eop_i,
  input  logic [lb_width(BUS_BYTES)-1:0]    last_bytes_i,
  input  logic                              ready_i,
  output logic                              can_load_o,
  output logic [BUS_BYTES*BYTE_WIDTH-1:0]   bus_o,
  output logic                              valid_o,
  output logic                              start_of_packet_o,
  output logic                              end_of_packet_o,
  output logic [lb_width(BUS_BYTES)-1:0]    last_bytes_o
);
  logic [BUS_BYTES*BYTE_WIDTH-1:0] bus_q;
  logic                            valid_q, sop_q, eop_q;
  logic [lb_width(BUS_BYTES)-1:0]  lb_q;
  assign can_load_o        = !valid_q || ready_i;
  assign bus_o             = bus_q;
  assign valid_o           = valid_q;
  assign start_of_packet_o = sop_q;
  assign end_of_packet_o   = eop_q;
  assign last_bytes_o      = lb_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      lb_q    <= '0;
    end else if (load_i) begin
      bus_q   <= data_i;
      valid_q <= 1'b1;
      sop_q   <= sop_i;
      eop_q   <= eop_i;
      lb_q    <= last_bytes_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/pkt_bus_tx.sv
// pkt_bus_tx: packs a byte stream MSB-first into BUS_BYTES-wide words with sop/eop/last_bytes framing
// Ports: clk, reset (sync, active-low); byte_i/byte_valid_i/byte_last_i/byte_ready_o byte input;
// bus_o/valid_o/ready_i/start_of_packet_o/end_of_packet_o/last_bytes_o word output;
// gap_i idle cycles after each packet (only with PKT_TX_GAP_EN); pkt_cnt_o packets sent.
// Macro PKT_TX_GAP_EN: enables the inter-packet GAP state and its counter.
module pkt_bus_tx
  import pkt_bus_pkg::*;
#(
  parameter int BUS_BYTES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BYTE_WIDTH-1:0]             byte_i,
  input  logic                              byte_valid_i,
  input  logic                              byte_last_i,
  output logic                              byte_ready_o,
  output logic [BUS_BYTES*BYTE_WIDTH-1:0]   bus_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic                              start_of_packet_o,
  output logic                              end_of_packet_o,
  output logic [lb_width(BUS_BYTES)-1:0]    last_bytes_o,
  input  logic [7:0]                        gap_i,
  output logic [CNT_W-1:0]                  pkt_cnt_o
);
  localparam int W    = BUS_BYTES * BYTE_WIDTH;
  localparam int LB_W = lb_width(BUS_BYTES);
  state_e            state_q, state_d;
  logic [W-1:0]      acc_q, acc_d, word;
  logic [LB_W-1:0]   idx_q, idx_d;
  logic              sop_pend_q, sop_pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              can_load, complete, accept, load;
`ifdef PKT_TX_GAP_EN
  logic [7:0]        gap_q, gap_d;
`else
  logic              unused_gap;
  assign unused_gap = ^gap_i;
`endif
  // a byte that completes a word needs the output register free (or draining) this cycle
  assign complete     = byte_last_i || idx_q == LB_W'(BUS_BYTES - 1);
  assign byte_ready_o = reset && (state_q == S_IDLE || state_q == S_FILL) && (!complete || can_load);
  assign accept       = byte_valid_i && byte_ready_o;
  assign load         = accept && complete;
  assign pkt_cnt_o    = cnt_q;
  always_comb begin
    word = acc_q;
    for (int k = 0; k < BUS_BYTES; k++)
      if (idx_q == LB_W'(k)) word[W-1-k*BYTE_WIDTH -: BYTE_WIDTH] = byte_i;
  end
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    sop_pend_d = sop_pend_q;
    cnt_d      = cnt_q;
`ifdef PKT_TX_GAP_EN
    gap_d      = gap_q;
`endif
    if (accept) begin
      acc_d      = load ? '0 : word;
      idx_d      = load ? '0 : idx_q + LB_W'(1);
      sop_pend_d = load ? byte_last_i : sop_pend_q;
      state_d    = byte_last_i ? S_DRAIN : S_FILL;
    end
    // in DRAIN the output register can only hold the eop word
    if (state_q == S_DRAIN && valid_o && ready_i) begin
      cnt_d   = cnt_q + CNT_W'(1);
`ifdef PKT_TX_GAP_EN
      gap_d   = gap_i;
      state_d = gap_i == '0 ? S_IDLE : S_GAP;
`else
      state_d = S_IDLE;
`endif
    end
`ifdef PKT_TX_GAP_EN
    if (state_q == S_GAP) begin
      gap_d   = gap_q - 8'd1;
      state_d = gap_q == 8'd1 ? S_IDLE : S_GAP;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      sop_pend_q <= 1'b1;
      cnt_q      <= '0;
`ifdef PKT_TX_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      sop_pend_q <= sop_pend_d;
      cnt_q      <= cnt_d;
`ifdef PKT_TX_GAP_EN
      gap_q      <= gap_d;
`endif
    end
  end
  pkt_bus_out_reg #(.BUS_BYTES(BUS_BYTES)) u_out (
    .clk               (clk),
    .reset             (reset),
    .load_i            (load),
    .data_i            (word),
    .sop_i             (sop_pend_q),
    .eop_i             (byte_last_i),
    .last_bytes_i      (byte_last_i ? idx_q + LB_W'(1) : '0),
    .ready_i           (ready_i),
    .can_load_o        (can_load),
    .bus_o             (bus_o),
    .valid_o           (valid_o),
    .start_of_packet_o (start_of_packet_o),
    .end_of_packet_o   (end_of_packet_o),
    .last_bytes_o      (last_bytes_o)
  );
endmodule

// File: tb/tb_pkt_bus_tx.sv
// tb_pkt_bus_tx: randomized self-checking bench for pkt_bus_tx against a packet-chunking reference model
module tb_pkt_bus_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_valid_i = 1'b0, byte_last_i = 1'b0, byte_ready_o;
  logic [31:0] bus_o;
  logic        valid_o, ready_i = 1'b0, start_of_packet_o, end_of_packet_o;
  logic [2:0]  last_bytes_o;
  logic [7:0]  gap_i = '0;
  logic [15:0] pkt_cnt_o;

  pkt_bus_tx #(.BUS_BYTES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_last_i(byte_last_i), .byte_ready_o(byte_ready_o), .bus_o(bus_o),
    .valid_o(valid_o), .ready_i(ready_i), .start_of_packet_o(start_of_packet_o),
    .end_of_packet_o(end_of_packet_o), .last_bytes_o(last_bytes_o), .gap_i(gap_i),
    .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  lb;
    int          cyc;
  } wd_t;

  logic [7:0] tx_b[$];
  bit         tx_l[$];
  int         pkt_start[$];
  wd_t        exp_q[$], got_q[$];
  int         acc_cyc[$];
  bit         rdy_q[$];
  int         cyc = 0, total = 0, bad = 0, stab_bad = 0, exp_pkts = 0;
  bit         timed_out;

  task automatic clear_stim();
    tx_b.delete(); tx_l.delete(); pkt_start.delete(); exp_q.delete(); rdy_q.delete();
  endtask

  // reference: a packet is cut into 4-byte chunks, each left-aligned and zero padded
  task automatic add_pkt(input int n, input bit rnd, input logic [7:0] base);
    logic [7:0] p[$];
    wd_t w;
    int m;
    pkt_start.push_back(tx_b.size());
    for (int i = 0; i < n; i++) begin
      p.push_back(rnd ? 8'($urandom) : base + 8'(i));
      tx_b.push_back(p[i]);
      tx_l.push_back(i == n - 1);
    end
    for (int s = 0; s < n; s += 4) begin
      m = (n - s < 4) ? n - s : 4;
      w.d = '0;
      for (int j = 0; j < m; j++) w.d[31-8*j -: 8] = p[s+j];
      w.sop = (s == 0);
      w.eop = (s + 4 >= n);
      w.lb  = w.eop ? 3'(m) : 3'd0;
      w.cyc = 0;
      exp_q.push_back(w);
    end
    exp_pkts++;
  endtask

  // streams tx_b through the DUT, collecting handshaken words and byte acceptance cycles
  task automatic run(input int rdy_pct, input int vld_pct);
    int i = 0;
    int limit;
    bit hold_prev = 0;
    logic [37:0] prev = '0, now;
    limit = cyc + 5000;
    got_q.delete(); acc_cyc.delete(); stab_bad = 0; timed_out = 0;
    while (got_q.size() < exp_q.size()) begin
      if (cyc > limit) begin timed_out = 1; break; end
      @(negedge clk);
      byte_valid_i = (i < tx_b.size()) && ($urandom_range(99) < vld_pct);
      byte_i       = (i < tx_b.size()) ? tx_b[i] : 8'h00;
      byte_last_i  = (i < tx_b.size()) ? tx_l[i] : 1'b0;
      ready_i      = (rdy_q.size() != 0) ? rdy_q.pop_front() : ($urandom_range(99) < rdy_pct);
      #4;
      cyc++;
      now = {bus_o, valid_o, start_of_packet_o, end_of_packet_o, last_bytes_o};
      if (hold_prev && now !== prev) stab_bad++;
      hold_prev = valid_o && !ready_i;
      prev = now;
      if (byte_valid_i && byte_ready_o) begin i++; acc_cyc.push_back(cyc); end
      if (valid_o && ready_i)
        got_q.push_back('{bus_o, start_of_packet_o, end_of_packet_o, last_bytes_o, cyc});
    end
    @(negedge clk);
    byte_valid_i = 0;
    byte_last_i  = 0;
    ready_i      = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 0; byte_valid_i = 1; byte_i = 8'h55; byte_last_i = 0; ready_i = 0; gap_i = 0;
    #4;
    total++;
    if (byte_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", byte_ready_o); end
    @(negedge clk); @(negedge clk);
    total++;
    if ({bus_o, valid_o, start_of_packet_o, end_of_packet_o, last_bytes_o} !== 38'd0 || pkt_cnt_o !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs got bus=%h v=%b s=%b e=%b lb=%0d cnt=%0d want all 0",
               bus_o, valid_o, start_of_packet_o, end_of_packet_o, last_bytes_o, pkt_cnt_o);
    end
    byte_valid_i = 0;
    reset = 1;
    exp_pkts = 0;
  endtask

  task automatic test_basic();
    clear_stim();
    add_pkt(8, 0, 8'h01);
    run(100, 100);
    total++;
    if (timed_out) begin bad++; $display("FAIL basic_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if (got_q[k].d !== exp_q[k].d || got_q[k].sop !== exp_q[k].sop || got_q[k].eop !== exp_q[k].eop || got_q[k].lb !== exp_q[k].lb) begin
          bad++;
          $display("FAIL basic_word%0d got %h s=%b e=%b lb=%0d want %h s=%b e=%b lb=%0d", k,
                   got_q[k].d, got_q[k].sop, got_q[k].eop, got_q[k].lb, exp_q[k].d, exp_q[k].sop, exp_q[k].eop, exp_q[k].lb);
        end
      end
      total++;
      if (acc_cyc[7] - acc_cyc[0] != 7) begin bad++; $display("FAIL basic_throughput got %0d cycles want 7", acc_cyc[7] - acc_cyc[0]); end
    end
    total++;
    if (pkt_cnt_o !== 16'(exp_pkts)) begin bad++; $display("FAIL basic_cnt got %0d want %0d", pkt_cnt_o, exp_pkts); end
  endtask

  task automatic test_one_byte();
    clear_stim();
    add_pkt(1, 0, 8'hAB);
    run(100, 100);
    total++;
    if (timed_out) begin bad++; $display("FAIL one_byte_timeout got %0d words want 1", got_q.size()); end
    else if (got_q[0].d !== 32'hAB000000 || got_q[0].sop !== 1'b1 || got_q[0].eop !== 1'b1 || got_q[0].lb !== 3'd1) begin
      bad++;
      $display("FAIL one_byte got %h s=%b e=%b lb=%0d want ab000000 s=1 e=1 lb=1",
               got_q[0].d, got_q[0].sop, got_q[0].eop, got_q[0].lb);
    end
    total++;
    if (pkt_cnt_o !== 16'(exp_pkts)) begin bad++; $display("FAIL one_byte_cnt got %0d want %0d", pkt_cnt_o, exp_pkts); end
  endtask

  task automatic test_eth42();
    clear_stim();
    add_pkt(42, 1, 8'h00);
    run(100, 100);
    total++;
    if (timed_out || got_q.size() != 11) begin bad++; $display("FAIL eth42_words got %0d want 11", got_q.size()); end
    else begin
      for (int k = 0; k < 11; k++) begin
        total++;
        if (got_q[k].d !== exp_q[k].d || got_q[k].sop !== exp_q[k].sop || got_q[k].eop !== exp_q[k].eop || got_q[k].lb !== exp_q[k].lb) begin
          bad++;
          $display("FAIL eth42_word%0d got %h s=%b e=%b lb=%0d want %h s=%b e=%b lb=%0d", k,
                   got_q[k].d, got_q[k].sop, got_q[k].eop, got_q[k].lb, exp_q[k].d, exp_q[k].sop, exp_q[k].eop, exp_q[k].lb);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_stim();
    add_pkt(16, 1, 8'h00);
    for (int k = 0; k < 8; k++) rdy_q.push_back(1'b1);
    for (int k = 0; k < 5; k++) rdy_q.push_back(1'b0);
    run(100, 100);
    total++;
    if (timed_out) begin bad++; $display("FAIL bp_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    else begin
      int c0, n;
      c0 = acc_cyc[0] - 1;
      n = 0;
      foreach (acc_cyc[k]) if (acc_cyc[k] - c0 >= 9 && acc_cyc[k] - c0 <= 13) n++;
      total++;
      if (n != 3) begin bad++; $display("FAIL bp_accepts_during_stall got %0d want 3", n); end
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if (got_q[k].d !== exp_q[k].d || got_q[k].sop !== exp_q[k].sop || got_q[k].eop !== exp_q[k].eop || got_q[k].lb !== exp_q[k].lb) begin
          bad++;
          $display("FAIL bp_word%0d got %h s=%b e=%b lb=%0d want %h s=%b e=%b lb=%0d", k,
                   got_q[k].d, got_q[k].sop, got_q[k].eop, got_q[k].lb, exp_q[k].d, exp_q[k].sop, exp_q[k].eop, exp_q[k].lb);
        end
      end
    end
    total++;
    if (stab_bad != 0) begin bad++; $display("FAIL bp_stable got %0d changes want 0", stab_bad); end
  endtask

  task automatic test_random();
    int eop_cyc[$];
    int ord_bad = 0;
    clear_stim();
    gap_i = 8'($urandom_range(3));
    for (int p = 0; p < 6; p++) add_pkt($urandom_range(1, 20), 1, 8'h00);
    run(60, 70);
    total++;
    if (timed_out) begin bad++; $display("FAIL rand_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if (got_q[k].d !== exp_q[k].d || got_q[k].sop !== exp_q[k].sop || got_q[k].eop !== exp_q[k].eop || got_q[k].lb !== exp_q[k].lb) begin
          bad++;
          $display("FAIL rand_word%0d got %h s=%b e=%b lb=%0d want %h s=%b e=%b lb=%0d", k,
                   got_q[k].d, got_q[k].sop, got_q[k].eop, got_q[k].lb, exp_q[k].d, exp_q[k].sop, exp_q[k].eop, exp_q[k].lb);
        end
        if (got_q[k].eop) eop_cyc.push_back(got_q[k].cyc);
      end
      for (int m = 1; m < pkt_start.size() && m <= eop_cyc.size(); m++)
        if (acc_cyc[pkt_start[m]] <= eop_cyc[m-1]) ord_bad++;
      total++;
      if (ord_bad != 0) begin bad++; $display("FAIL rand_order got %0d early packet starts want 0", ord_bad); end
    end
    total++;
    if (stab_bad != 0) begin bad++; $display("FAIL rand_stable got %0d changes want 0", stab_bad); end
    total++;
    if (pkt_cnt_o !== 16'(exp_pkts)) begin bad++; $display("FAIL rand_cnt got %0d want %0d", pkt_cnt_o, exp_pkts); end
    gap_i = 0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      byte_valid_i = 1; byte_i = 8'(8'hC0 + i); byte_last_i = 0; ready_i = 1;
    end
    @(negedge clk);
    byte_valid_i = 0; reset = 0;
    @(negedge clk);
    reset = 1;
    total++;
    if ({bus_o, valid_o, start_of_packet_o, end_of_packet_o, last_bytes_o} !== 38'd0 || pkt_cnt_o !== 16'd0) begin
      bad++;
      $display("FAIL midreset_outputs got bus=%h v=%b s=%b e=%b lb=%0d cnt=%0d want all 0",
               bus_o, valid_o, start_of_packet_o, end_of_packet_o, last_bytes_o, pkt_cnt_o);
    end
    exp_pkts = 0;
    clear_stim();
    add_pkt(5, 0, 8'h40);
    run(100, 100);
    total++;
    if (timed_out) begin bad++; $display("FAIL midreset_timeout got %0d words want 2", got_q.size()); end
    else begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got_q[k].d !== exp_q[k].d || got_q[k].sop !== exp_q[k].sop || got_q[k].eop !== exp_q[k].eop || got_q[k].lb !== exp_q[k].lb) begin
          bad++;
          $display("FAIL midreset_word%0d got %h s=%b e=%b lb=%0d want %h s=%b e=%b lb=%0d", k,
                   got_q[k].d, got_q[k].sop, got_q[k].eop, got_q[k].lb, exp_q[k].d, exp_q[k].sop, exp_q[k].eop, exp_q[k].lb);
        end
      end
    end
    total++;
    if (pkt_cnt_o !== 16'd1) begin bad++; $display("FAIL midreset_cnt got %0d want 1", pkt_cnt_o); end
  endtask

  task automatic test_back_to_back(input int g);
    int exp_gap, seen;
    clear_stim();
    gap_i = 8'(g);
`ifdef PKT_TX_GAP_EN
    exp_gap = g;
`else
    exp_gap = 0;
`endif
    add_pkt(5, 1, 8'h00);
    add_pkt(3, 1, 8'h00);
    run(100, 100);
    total++;
    if (timed_out) begin bad++; $display("FAIL b2b_gap%0d_timeout got %0d words want 3", g, got_q.size()); end
    else begin
      seen = acc_cyc[5] - got_q[1].cyc - 1;
      total++;
      if (seen != exp_gap) begin bad++; $display("FAIL b2b_gap%0d got %0d idle cycles want %0d", g, seen, exp_gap); end
    end
    repeat (g + 2) @(negedge clk);
    gap_i = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_one_byte();
    test_eth42();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_back_to_back(3);
    test_back_to_back(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
